cache_way_select: RTL and testbench
===================================

CACHE_WAY_SELECT -- requirements
Module: cache_way_select

Interface
REQ-001 Parameter CACHE_LINES, default 256, number of sets (power of two).
REQ-002 Parameter LINE_SIZE_BYTES, default 64, bytes per line (power of two, at least 4).
REQ-003 Parameter DATA_WIDTH, default 32, read word width.
REQ-004 Parameter ADDRESS_WIDTH, default 32, byte address width.
REQ-005 Parameter WAYS, default 4, associativity.
REQ-006 Derived widths:
- OFFSET_WIDTH = log2(LINE_SIZE_BYTES).
- INDEX_WIDTH = log2(CACHE_LINES).
- TAG_BITS = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH.
- Defaults give 6 / 8 / 18.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 i_rd_en  input  1  lookup request.
REQ-010 i_address  input  ADDRESS_WIDTH  lookup byte address, split as {tag, index, offset}, MSB to LSB.
REQ-011 i_fill_en  input  1  line fill request.
REQ-012 i_fill_address  input  ADDRESS_WIDTH  fill address; tag and index used, offset ignored.
REQ-013 i_fill_way  input  log2(WAYS)  way to write.
REQ-014 i_fill_data  input  LINE_SIZE_BYTES*8  full line; byte 0 in bits [7:0].
REQ-015 o_data  output  DATA_WIDTH  selected word.
REQ-016 o_cache_hit  output  1  lookup hit.
REQ-017 o_hit_way  output  log2(WAYS)  index of the hitting way.

Function
REQ-018 Storage per set and way: valid bit, tag (TAG_BITS), line data (LINE_SIZE_BYTES*8).
REQ-019 Lookup reads all WAYS entries of set i_address[index].
REQ-020 Each way has its own comparator: tag-equal when the stored tag equals i_address[tag].
REQ-021 Each way's select term is tag-equal AND valid; the select vector is WAYS bits wide.
REQ-022 Hit = OR of the select vector.
REQ-023 The select vector drives a one-hot line mux; if more than one way is selected, the lowest-numbered way wins.
REQ-024 Word select: from the muxed line, output word number offset[OFFSET_WIDTH-1:2]; word k is line bits [32k+31:32k]; offset[1:0] is ignored.
REQ-025 Latency one cycle: when i_rd_en is high at edge N, o_data, o_cache_hit and o_hit_way are valid after edge N and hold until the next i_rd_en edge.
REQ-026 On a miss: o_cache_hit=0, o_data=0, o_hit_way=0.
REQ-027 Fill: when i_fill_en is high at a clock edge, the entry at [fill index][i_fill_way] gets tag, data and valid=1.
REQ-028 A fill overwrites any previous contents of that way; no eviction policy and no dirty handling exist in this block.
REQ-029 Lookup and fill to the same set on the same edge: the lookup sees the contents before the fill (read-before-write).
REQ-030 Lookup and fill to different sets on the same edge: both complete independently.
REQ-031 A fill with the same tag as another valid way in the set is permitted; the priority rule of REQ-023 applies.

Reset
REQ-032 While rst is high (asynchronous assertion), all valid bits are 0, o_data=0, o_cache_hit=0, o_hit_way=0.
REQ-033 Tag and data storage are not cleared by reset.
REQ-034 Lookups and fills presented while rst is high are ignored.
REQ-035 After rst deasserts, the first edge with i_rd_en or i_fill_en is processed normally.
REQ-036 Reset asserted mid-operation drops any pending result; outputs read 0 until a new lookup completes.

Verification
REQ-037 Cold miss: after reset, read 0x12345678 -> o_cache_hit=0, o_data=0 one cycle later.
REQ-038 Fill and hit:
- Fill way 2 at address 0x0000_1040, line bytes = byte number (0x00..0x3F).
- Then read 0x0000_1048 -> hit=1, o_hit_way=2, o_data=0x0B0A0908.
REQ-039 Tag mismatch: after REQ-038, read 0x0004_1048 (same index, different tag) -> hit=0, o_data=0.
REQ-040 Multi-hit priority:
- Fill ways 1 and 3 of set 5 with the same tag, distinct data.
- Read that set/tag -> o_hit_way=1, way-1 data returned.
REQ-041 Same-set collision: fill way 0 and read the same address on the same edge -> miss; read again on the next cycle -> hit.
REQ-042 Reset mid-run: after REQ-038, pulse rst asynchronously between edges -> outputs 0 immediately; re-read 0x0000_1048 -> miss.

Source files
------------

// File: rtl/cache_way_select_if.sv
// Lookup and fill bus of the set-associative way selector.
// Both requests are single-cycle strobes with no ready; lookup results appear one cycle later and hold.
interface cache_way_select_if #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int WAYS            = 4
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                         i_rd_en;
  logic [ADDRESS_WIDTH-1:0]     i_address;
  logic                         i_fill_en;
  logic [ADDRESS_WIDTH-1:0]     i_fill_address;
  logic [WAY_W-1:0]             i_fill_way;
  logic [LINE_SIZE_BYTES*8-1:0] i_fill_data;
  logic [DATA_WIDTH-1:0]        o_data;
  logic                         o_cache_hit;
  logic [WAY_W-1:0]             o_hit_way;

  modport master (
    output i_rd_en, i_address, i_fill_en, i_fill_address, i_fill_way, i_fill_data,
    input  o_data, o_cache_hit, o_hit_way
  );

  modport slave (
    input  i_rd_en, i_address, i_fill_en, i_fill_address, i_fill_way, i_fill_data,
    output o_data, o_cache_hit, o_hit_way
  );
endinterface

// File: rtl/cache_way_select.sv
// N-way set-associative tag compare and line/word select with registered lookup results.
// Only valid bits and result registers are reset; tag and line storage keep their contents.
module cache_way_select #(
  parameter int CACHE_LINES     = 256,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WAYS            = 4
) (
  input logic clk,
  input logic rst,
  cache_way_select_if.slave bus
);
  localparam int OFFSET_WIDTH = $clog2(LINE_SIZE_BYTES);
  localparam int INDEX_WIDTH  = $clog2(CACHE_LINES);
  localparam int TAG_BITS     = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINE_BITS    = LINE_SIZE_BYTES * 8;
  localparam int WORDS        = LINE_SIZE_BYTES / 4;
  localparam int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [CACHE_LINES-1:0][WAYS-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0]              tag_q  [CACHE_LINES][WAYS];
  logic [LINE_BITS-1:0]             line_q [CACHE_LINES][WAYS];

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  hit_q, hit_d;
  logic [WAY_W-1:0]      hit_way_q, hit_way_d;

  logic [INDEX_WIDTH-1:0]  rd_index;
  logic [TAG_BITS-1:0]     rd_tag;
  logic [OFFSET_WIDTH-1:0] rd_offset;
  logic [INDEX_WIDTH-1:0]  fill_index;
  logic [TAG_BITS-1:0]     fill_tag;

  logic [WAYS-1:0]       sel_vec;
  logic [WAYS-1:0]       sel_onehot;
  logic [LINE_BITS-1:0]  muxed_line;
  logic [DATA_WIDTH-1:0] muxed_word;
  logic [WAY_W-1:0]      enc_way;

  assign rd_index   = bus.i_address[OFFSET_WIDTH +: INDEX_WIDTH];
  assign rd_tag     = bus.i_address[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign rd_offset  = bus.i_address[OFFSET_WIDTH-1:0];
  assign fill_index = bus.i_fill_address[OFFSET_WIDTH +: INDEX_WIDTH];
  assign fill_tag   = bus.i_fill_address[ADDRESS_WIDTH-1 -: TAG_BITS];

  // Per-way comparators qualified by valid.
  always_comb begin
    sel_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      sel_vec[w] = valid_q[rd_index][w] && (tag_q[rd_index][w] == rd_tag);
    end
  end

  // Isolating the lowest set bit makes the lowest-numbered way win a multi-hit.
  assign sel_onehot = sel_vec & (~sel_vec + WAYS'(1));

  always_comb begin
    muxed_line = '0;
    enc_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      muxed_line = muxed_line | (line_q[rd_index][w] & {LINE_BITS{sel_onehot[w]}});
      if (sel_onehot[w]) begin
        enc_way = enc_way | WAY_W'(w);
      end
    end
  end

  // Byte offset bits [1:0] fall away in the shift; only the word number selects.
  always_comb begin
    muxed_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if ((rd_offset >> 2) == OFFSET_WIDTH'(k)) begin
        muxed_word = muxed_line[k*32 +: DATA_WIDTH];
      end
    end
  end

  // A miss leaves the mux at zero, so data and way need no separate clearing.
  always_comb begin
    rd_data_d = rd_data_q;
    hit_d     = hit_q;
    hit_way_d = hit_way_q;
    if (bus.i_rd_en) begin
      rd_data_d = muxed_word;
      hit_d     = |sel_vec;
      hit_way_d = enc_way;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (bus.i_fill_en) begin
      valid_d[fill_index][bus.i_fill_way] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      rd_data_q <= '0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
    end
  end

  // Lookup above samples the old arrays on the same edge, giving read-before-write.
  always_ff @(posedge clk) begin
    if (bus.i_fill_en && !rst) begin
      tag_q[fill_index][bus.i_fill_way]  <= fill_tag;
      line_q[fill_index][bus.i_fill_way] <= bus.i_fill_data;
    end
  end

  assign bus.o_data      = rd_data_q;
  assign bus.o_cache_hit = hit_q;
  assign bus.o_hit_way   = hit_way_q;
endmodule

// File: tb/tb_cache_way_select.sv
// Directed bench for cache_way_select: fills, lookups, priority, collisions and reset.
module tb_cache_way_select;
  localparam int CACHE_LINES     = 256;
  localparam int LINE_SIZE_BYTES = 64;
  localparam int DATA_WIDTH      = 32;
  localparam int ADDRESS_WIDTH   = 32;
  localparam int WAYS            = 4;
  localparam int LINE_BITS       = LINE_SIZE_BYTES * 8;
  localparam int RES_W           = 1 + 2 + DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;
  int tests_run    = 0;
  int tests_failed = 0;
  logic [RES_W-1:0] exp_q[$];

  cache_way_select_if #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH), .LINE_SIZE_BYTES(LINE_SIZE_BYTES),
    .DATA_WIDTH(DATA_WIDTH), .WAYS(WAYS)
  ) bus ();

  cache_way_select #(
    .CACHE_LINES(CACHE_LINES), .LINE_SIZE_BYTES(LINE_SIZE_BYTES),
    .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH), .WAYS(WAYS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_BITS-1:0] byte_ramp_line();
    logic [LINE_BITS-1:0] l;
    for (int k = 0; k < LINE_SIZE_BYTES; k++) l[k*8 +: 8] = 8'(k);
    return l;
  endfunction

  function automatic logic [LINE_BITS-1:0] word_line(input logic [31:0] base);
    logic [LINE_BITS-1:0] l;
    for (int k = 0; k < LINE_SIZE_BYTES / 4; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic idle_inputs();
    bus.i_rd_en        = 1'b0;
    bus.i_address      = '0;
    bus.i_fill_en      = 1'b0;
    bus.i_fill_address = '0;
    bus.i_fill_way     = '0;
    bus.i_fill_data    = '0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    @(negedge clk);
    bus.i_rd_en   = 1'b1;
    bus.i_address = addr;
    @(posedge clk);
    #1;
    bus.i_rd_en = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [1:0] way, input logic [LINE_BITS-1:0] line);
    @(negedge clk);
    bus.i_fill_en      = 1'b1;
    bus.i_fill_address = addr;
    bus.i_fill_way     = way;
    bus.i_fill_data    = line;
    @(posedge clk);
    #1;
    bus.i_fill_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got hit=%0b way=%0d data=%h, want all 0",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    do_read(32'h1234_5678);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== '0) begin
      tests_failed++;
      $display("FAIL cold_miss: got hit=%0b way=%0d data=%h, want hit=0 way=0 data=0",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
  endtask

  task automatic test_fill_hit();
    logic [31:0] addrs [4] = '{32'h0000_1048, 32'h0000_1040, 32'h0000_107F, 32'h0000_104A};
    logic [31:0] words [4] = '{32'h0B0A_0908, 32'h0302_0100, 32'h3F3E_3D3C, 32'h0B0A_0908};
    do_fill(32'h0000_1040, 2'd2, byte_ramp_line());
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i]);
      tests_run++;
      if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd2, words[i]}) begin
        tests_failed++;
        $display("FAIL fill_hit[%h]: got hit=%0b way=%0d data=%h, want hit=1 way=2 data=%h",
                 addrs[i], bus.o_cache_hit, bus.o_hit_way, bus.o_data, words[i]);
      end
    end
  endtask

  task automatic test_tag_mismatch();
    do_read(32'h0004_1048);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== '0) begin
      tests_failed++;
      $display("FAIL tag_mismatch: got hit=%0b way=%0d data=%h, want all 0",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
  endtask

  task automatic test_hold();
    do_read(32'h0000_1048);
    @(negedge clk);
    bus.i_address = 32'h0004_1048;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd2, 32'h0B0A_0908}) begin
      tests_failed++;
      $display("FAIL hold: got hit=%0b way=%0d data=%h, want hit=1 way=2 data=0b0a0908",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
  endtask

  task automatic test_multi_hit();
    do_fill(32'h0055_4140, 2'd3, word_line(32'h3300_0000));
    do_fill(32'h0055_4140, 2'd1, word_line(32'h1100_0000));
    do_read(32'h0055_414C);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd1, 32'h1100_0003}) begin
      tests_failed++;
      $display("FAIL multi_hit_prio: got hit=%0b way=%0d data=%h, want hit=1 way=1 data=11000003",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    // Retag way 1: the old tag now only matches way 3.
    do_fill(32'h0055_8140, 2'd1, word_line(32'h5500_0000));
    do_read(32'h0055_414C);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd3, 32'h3300_0003}) begin
      tests_failed++;
      $display("FAIL overwrite_old_tag: got hit=%0b way=%0d data=%h, want hit=1 way=3 data=33000003",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    do_read(32'h0055_814C);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd1, 32'h5500_0003}) begin
      tests_failed++;
      $display("FAIL overwrite_new_tag: got hit=%0b way=%0d data=%h, want hit=1 way=1 data=55000003",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    bus.i_fill_en      = 1'b1;
    bus.i_fill_address = 32'h00AA_8240;
    bus.i_fill_way     = 2'd0;
    bus.i_fill_data    = word_line(32'h7700_0000);
    bus.i_rd_en        = 1'b1;
    bus.i_address      = 32'h00AA_8244;
    @(posedge clk);
    #1;
    bus.i_fill_en = 1'b0;
    bus.i_rd_en   = 1'b0;
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== '0) begin
      tests_failed++;
      $display("FAIL collision_same_edge: got hit=%0b way=%0d data=%h, want all 0",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    do_read(32'h00AA_8244);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd0, 32'h7700_0001}) begin
      tests_failed++;
      $display("FAIL collision_next: got hit=%0b way=%0d data=%h, want hit=1 way=0 data=77000001",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
  endtask

  task automatic test_diff_set_same_edge();
    @(negedge clk);
    bus.i_fill_en      = 1'b1;
    bus.i_fill_address = 32'h00AA_8280;
    bus.i_fill_way     = 2'd3;
    bus.i_fill_data    = word_line(32'h9900_0000);
    bus.i_rd_en        = 1'b1;
    bus.i_address      = 32'h0000_1048;
    @(posedge clk);
    #1;
    bus.i_fill_en = 1'b0;
    bus.i_rd_en   = 1'b0;
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd2, 32'h0B0A_0908}) begin
      tests_failed++;
      $display("FAIL diff_set_read: got hit=%0b way=%0d data=%h, want hit=1 way=2 data=0b0a0908",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    do_read(32'h00AA_82BC);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd3, 32'h9900_000F}) begin
      tests_failed++;
      $display("FAIL diff_set_fill: got hit=%0b way=%0d data=%h, want hit=1 way=3 data=9900000f",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5] = '{32'h0000_1040, 32'h0000_1044, 32'h0000_107C,
                               32'h0004_1048, 32'h0055_414C};
    logic [RES_W-1:0] got;
    exp_q.push_back({1'b1, 2'd2, 32'h0302_0100});
    exp_q.push_back({1'b1, 2'd2, 32'h0706_0504});
    exp_q.push_back({1'b1, 2'd2, 32'h3F3E_3D3C});
    exp_q.push_back({1'b0, 2'd0, 32'h0000_0000});
    exp_q.push_back({1'b1, 2'd3, 32'h3300_0003});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.i_rd_en   = 1'b1;
      bus.i_address = addrs[i];
      @(posedge clk);
      #1;
      got = {bus.o_cache_hit, bus.o_hit_way, bus.o_data};
      tests_run++;
      if (got !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got hit/way/data=%h, want %h", i, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    bus.i_rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_read(32'h0000_1048);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: got hit=%0b way=%0d data=%h, want all 0",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    // Requests during reset must be dropped, including a fill that would re-validate the line.
    bus.i_rd_en        = 1'b1;
    bus.i_address      = 32'h0000_1048;
    bus.i_fill_en      = 1'b1;
    bus.i_fill_address = 32'h0000_1040;
    bus.i_fill_way     = 2'd2;
    bus.i_fill_data    = byte_ramp_line();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ignores_read: got hit=%0b way=%0d data=%h, want all 0",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got hit=%0b way=%0d data=%h, want all 0",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    do_read(32'h0000_1048);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_reread_miss: got hit=%0b way=%0d data=%h, want all 0",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
    do_fill(32'h0000_1040, 2'd2, byte_ramp_line());
    do_read(32'h0000_1048);
    tests_run++;
    if ({bus.o_cache_hit, bus.o_hit_way, bus.o_data} !== {1'b1, 2'd2, 32'h0B0A_0908}) begin
      tests_failed++;
      $display("FAIL reset_refill_hit: got hit=%0b way=%0d data=%h, want hit=1 way=2 data=0b0a0908",
               bus.o_cache_hit, bus.o_hit_way, bus.o_data);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_fill_hit();
    test_tag_mismatch();
    test_hold();
    test_multi_hit();
    test_collision();
    test_diff_set_same_edge();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
